alu_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 32-bit adder/subtractor. Each requester sends an operation with a valid/ready handshake. The arbiter grants one requester, drives the single adder instance for one cycle, and registers Result and flags. It then returns them to the granted requester over a per-requester valid/ready response channel. The block sits between the instruction-issue logic and the adder, so one arithmetic unit serves two pipelines.

---
 rtl/alu_arb_pkg.sv | 29 ++
 rtl/alu_arbiter_adder.sv | 35 +++
 rtl/alu_arbiter.sv | 179 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg
//   Shared constants and types for the two-requester adder arbiter:
//   operand width, requester count, ALUop encodings and the sequencer
//   state encoding.
//   No ports (package).

package alu_arb_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NREQ       = 2;

  localparam logic [2:0] ALUOP_AND = 3'b000;
  localparam logic [2:0] ALUOP_OR  = 3'b001;
  localparam logic [2:0] ALUOP_ADD = 3'b010;
  localparam logic [2:0] ALUOP_SUB = 3'b110;
  localparam logic [2:0] ALUOP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } alu_arb_state_e;

  // SUB and SLT both run the adder in subtract mode.
  function automatic logic op_uses_sub(input logic [2:0] op);
    return (op == ALUOP_SUB) || (op == ALUOP_SLT);
  endfunction

endpackage

// File: rtl/alu_arbiter_adder.sv
// alu_arbiter_adder
//   Shared 32-bit adder/subtractor. Purely combinational; in subtract
//   mode it computes a + ~b + 1.
//   Ports:
//     a_i, b_i    operands
//     sub_i       1 = subtract, 0 = add
//     sum_o       a +/- b
//     carry_o     raw carry out of the MSB (for subtract, 1 = no borrow)
//     overflow_o  signed overflow of the operation

module alu_arbiter_adder
  import alu_arb_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  sub_i,
  output logic [DATA_WIDTH-1:0] sum_o,
  output logic                  carry_o,
  output logic                  overflow_o
);

  logic [DATA_WIDTH-1:0] b_eff;
  logic [DATA_WIDTH:0]   full;

  assign b_eff = sub_i ? ~b_i : b_i;
  assign full  = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, sub_i};

  assign sum_o   = full[DATA_WIDTH-1:0];
  assign carry_o = full[DATA_WIDTH];

  // Overflow when both effective operands share a sign the sum does not.
  assign overflow_o = (a_i[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
                      (sum_o[DATA_WIDTH-1] != a_i[DATA_WIDTH-1]);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-requester arbiter/sequencer in front of one shared adder.
//   IDLE grants a requester and captures its operation, EXEC runs the
//   adder and registers result/flags, RESP holds the response until the
//   granted requester takes it. One operation in flight at a time.
//
//   Build option ALU_ARB_ROUNDROBIN_EN:
//     defined   - contested grants alternate using a last_grant register
//     undefined - requester 0 always wins a contested cycle
//
//   Ports:
//     clk, rst     clock; asynchronous active-high reset
//     req_valid    per-requester operation valid
//     req_ready    per-requester accept (combinational, IDLE only)
//     req_A/req_B  packed operands, requester i at [i*32 +: 32]
//     req_ALUop    packed opcodes, requester i at [i*3 +: 3]
//     rsp_valid    per-requester response valid
//     rsp_ready    per-requester response consume
//     rsp_Result   registered result (shared)
//     rsp_flags    registered {Overflow, CarryOut, Zero}
//     rsp_err      opcode not supported by this block

module alu_arbiter
  import alu_arb_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*DATA_WIDTH-1:0] req_A,
  input  logic [NREQ*DATA_WIDTH-1:0] req_B,
  input  logic [NREQ*3-1:0]          req_ALUop,
  output logic [NREQ-1:0]            rsp_valid,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_Result,
  output logic [2:0]                 rsp_flags,
  output logic                       rsp_err
);

  alu_arb_state_e state_q, state_d;

  logic                  grant_q;
  logic                  grant_sel;
  logic                  accept;
  logic                  rsp_done;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [2:0]            op_q;

  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [2:0]            flags_q, flags_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] sum;
  logic                  carry;
  logic                  ovf;
  logic                  slt_bit;

  // ---------------------------------------------------------------
  // Arbitration. With a single requester, ~req_valid[0] picks it;
  // with none, grant_sel is unused because accept is low.
  // ---------------------------------------------------------------
`ifdef ALU_ARB_ROUNDROBIN_EN
  logic last_grant_q;

  always_comb begin
    if (&req_valid) grant_sel = ~last_grant_q;
    else            grant_sel = ~req_valid[0];
  end

  // Reset to 1 so requester 0 wins the first contested cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           last_grant_q <= 1'b1;
    else if (rsp_done) last_grant_q <= grant_q;
  end
`else
  always_comb grant_sel = ~req_valid[0];
`endif

  assign accept   = (state_q == ST_IDLE) && (|req_valid);
  assign rsp_done = (state_q == ST_RESP) && rsp_ready[grant_q];

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_sel] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == ST_RESP) rsp_valid[grant_q] = 1'b1;
  end

  // ---------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)   state_d = ST_EXEC;
      ST_EXEC:               state_d = ST_RESP;
      ST_RESP: if (rsp_done) state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Operation capture at grant time; held through EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else if (accept) begin
      grant_q <= grant_sel;
      a_q     <= grant_sel ? req_A[2*DATA_WIDTH-1:DATA_WIDTH] : req_A[DATA_WIDTH-1:0];
      b_q     <= grant_sel ? req_B[2*DATA_WIDTH-1:DATA_WIDTH] : req_B[DATA_WIDTH-1:0];
      op_q    <= grant_sel ? req_ALUop[5:3] : req_ALUop[2:0];
    end
  end

  // ---------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------
  alu_arbiter_adder u_adder (
    .a_i        (a_q),
    .b_i        (b_q),
    .sub_i      (op_uses_sub(op_q)),
    .sum_o      (sum),
    .carry_o    (carry),
    .overflow_o (ovf)
  );

  // Signed less-than: sign of the difference corrected by overflow.
  assign slt_bit = sum[DATA_WIDTH-1] ^ ovf;

  // CarryOut is reported as a borrow for SUB/SLT, hence ~carry.
  always_comb begin
    result_d = '0;
    flags_d  = 3'b000;
    err_d    = 1'b0;
    unique case (op_q)
      ALUOP_ADD: begin
        result_d = sum;
        flags_d  = {ovf, carry, (sum == '0)};
      end
      ALUOP_SUB: begin
        result_d = sum;
        flags_d  = {ovf, ~carry, (sum == '0)};
      end
      ALUOP_SLT: begin
        result_d = {{(DATA_WIDTH-1){1'b0}}, slt_bit};
        flags_d  = {ovf, ~carry, ~slt_bit};
      end
      ALUOP_AND, ALUOP_OR: err_d = 1'b1;
      default:             err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= 3'b000;
      err_q    <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
    end
  end

  assign rsp_Result = result_q;
  assign rsp_flags  = flags_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Directed bench for alu_arbiter. Inputs change on the falling edge,
//   outputs are sampled 1 ns after the falling edge.

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [63:0] req_A = '0;
  logic [63:0] req_B = '0;
  logic [5:0]  req_ALUop = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [31:0] rsp_Result;
  logic [2:0]  rsp_flags;
  logic        rsp_err;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_A      (req_A),
    .req_B      (req_B),
    .req_ALUop  (req_ALUop),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_Result (rsp_Result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int r, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
    if (r == 0) begin
      req_A[31:0]    = a;
      req_B[31:0]    = b;
      req_ALUop[2:0] = op;
      req_valid      = 2'b01;
    end else begin
      req_A[63:32]   = a;
      req_B[63:32]   = b;
      req_ALUop[5:3] = op;
      req_valid      = 2'b10;
    end
  endtask

  // Full single operation with rsp_ready already high; starts on a
  // falling edge in IDLE and ends on a falling edge back in IDLE.
  task automatic single_op(input string tag, input int r,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic [31:0] exp_res,
                           input logic [2:0] exp_flags, input logic exp_err);
    logic [1:0] oh;
    oh = (r == 0) ? 2'b01 : 2'b10;
    issue(r, a, b, op);
    #1 chk({tag, " req_ready"}, req_ready, oh);
    @(negedge clk);
    req_valid = 2'b00;
    #1 chk({tag, " exec rsp_valid"}, rsp_valid, 2'b00);
    @(negedge clk);
    #1;
    chk({tag, " rsp_valid"}, rsp_valid, oh);
    chk({tag, " result"}, rsp_Result, exp_res);
    chk({tag, " flags"}, rsp_flags, exp_flags);
    chk({tag, " err"}, rsp_err, exp_err);
    @(negedge clk);
    #1 chk({tag, " done rsp_valid"}, rsp_valid, 2'b00);
  endtask

  initial begin
    logic exp_g;
    int   waited;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst req_ready", req_ready, 2'b00);
    chk("rst rsp_valid", rsp_valid, 2'b00);
    chk("rst result", rsp_Result, 32'h0);
    chk("rst flags", rsp_flags, 3'b000);
    chk("rst err", rsp_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 2'b11;
    @(negedge clk);

    // Arithmetic vectors
    single_op("add7_5",   0, 32'd7,        32'd5, 3'b010, 32'd12,       3'b000, 1'b0);
    single_op("sub5_5",   1, 32'd5,        32'd5, 3'b110, 32'd0,        3'b001, 1'b0);
    single_op("sub3_5",   1, 32'd3,        32'd5, 3'b110, 32'hFFFFFFFE, 3'b010, 1'b0);
    single_op("add_ovf",  0, 32'h7FFFFFFF, 32'd1, 3'b010, 32'h80000000, 3'b100, 1'b0);
    single_op("slt3_5",   0, 32'd3,        32'd5, 3'b111, 32'd1,        3'b010, 1'b0);
    single_op("slt_m1_5", 1, 32'hFFFFFFFF, 32'd5, 3'b111, 32'd1,        3'b000, 1'b0);
    single_op("slt5_3",   0, 32'd5,        32'd3, 3'b111, 32'd0,        3'b001, 1'b0);
    single_op("illegal",  0, 32'd7,        32'd5, 3'b011, 32'd0,        3'b000, 1'b1);

    // Response backpressure; requester 1 keeps asking meanwhile and only
    // requester 1 signals rsp_ready, which must not release requester 0.
    rsp_ready = 2'b00;
    issue(0, 32'd1, 32'd2, 3'b010);
    #1 chk("bp req_ready", req_ready, 2'b01);
    @(negedge clk);
    issue(1, 32'd10, 32'd20, 3'b010);
    @(negedge clk);
    #1;
    chk("bp rsp_valid", rsp_valid, 2'b01);
    chk("bp result", rsp_Result, 32'd3);
    rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp hold rsp_valid", rsp_valid, 2'b01);
      chk("bp hold result", rsp_Result, 32'd3);
      chk("bp hold req_ready", req_ready, 2'b00);
    end
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    @(negedge clk);
    #1 chk("bp release rsp_valid", rsp_valid, 2'b00);
    rsp_ready = 2'b11;
    @(negedge clk);

    // Reset while in EXEC
    issue(1, 32'd9, 32'd4, 3'b110);
    #1 chk("abort req_ready", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b1;
    #1;
    chk("abort rsp_valid", rsp_valid, 2'b00);
    chk("abort result", rsp_Result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("abort no rsp", rsp_valid, 2'b00);
    end
    @(negedge clk);

    // Both requesters valid continuously, straight after reset
    req_A     = {32'd10, 32'd1};
    req_B     = {32'd20, 32'd1};
    req_ALUop = {3'b010, 3'b010};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_ROUNDROBIN_EN
      exp_g = (k % 2) == 1;
`else
      exp_g = 1'b0;
`endif
      waited = 0;
      #1;
      while (req_ready == 2'b00 && waited < 5) begin
        @(negedge clk);
        #1;
        waited++;
      end
      chk("arb grant", req_ready, exp_g ? 2'b10 : 2'b01);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("arb rsp_valid", rsp_valid, exp_g ? 2'b10 : 2'b01);
      chk("arb result", rsp_Result, exp_g ? 32'd30 : 32'd2);
      @(negedge clk);
    end
    req_valid = 2'b00;
    @(negedge clk);

    single_op("after", 1, 32'd100, 32'd23, 3'b010, 32'd123, 3'b000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
